// File: rtl/read_eeprom.sv
// Random-read sequencer for an I2C EEPROM: writes a 16-bit memory address, then
// reads N bytes through an i2c_master running on a slower divided clock.
module read_eeprom #(
  parameter int unsigned START_CYCLES = 1000,
  parameter int unsigned GAP_CYCLES   = 20000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  slave_addr_w,
  input  logic [15:0] mem_addr_w,
  input  logic [7:0]  read_nbytes_w,
  input  logic        start,
  output logic [6:0]  i2c_slave_addr,
  output logic        i2c_rw,
  output logic [7:0]  i2c_write_data,
  output logic [7:0]  i2c_nbytes,
  input  logic [7:0]  i2c_read_data,
  input  logic        i2c_tx_data_req,
  input  logic        i2c_rx_data_ready,
  output logic        i2c_start,
  output logic [7:0]  data_out,
  output logic        byte_ready
);

  localparam int unsigned CNT_MAX = (START_CYCLES > GAP_CYCLES) ? START_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    W_START,
    W_DATA,
    GAP,
    R_START,
    R_DATA
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [7:0]        byte_cnt;
  logic [7:0]        nbytes_q;
  logic [7:0]        mem_lo_q;
  logic              fall_seen;

  logic [1:0] tx_sync, rx_sync, start_sync;
  logic       tx_d, rx_d, start_d;
  logic       tx_fall, rx_rise, start_rise;

  // Master handshakes live in the divided-clock domain; resynchronise and edge-detect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_sync    <= '0;
      rx_sync    <= '0;
      start_sync <= '0;
      tx_d       <= 1'b0;
      rx_d       <= 1'b0;
      start_d    <= 1'b0;
    end else begin
      tx_sync    <= {tx_sync[0], i2c_tx_data_req};
      rx_sync    <= {rx_sync[0], i2c_rx_data_ready};
      start_sync <= {start_sync[0], start};
      tx_d       <= tx_sync[1];
      rx_d       <= rx_sync[1];
      start_d    <= start_sync[1];
    end
  end

  assign tx_fall    = tx_d & ~tx_sync[1];
  assign rx_rise    = rx_sync[1] & ~rx_d;
  assign start_rise = start_sync[1] & ~start_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      byte_cnt       <= '0;
      nbytes_q       <= '0;
      mem_lo_q       <= '0;
      fall_seen      <= 1'b0;
      i2c_slave_addr <= '0;
      i2c_rw         <= 1'b0;
      i2c_write_data <= '0;
      i2c_nbytes     <= '0;
      i2c_start      <= 1'b0;
      data_out       <= '0;
      byte_ready     <= 1'b0;
    end else begin
      byte_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (start_rise) begin
            i2c_slave_addr <= slave_addr_w;
            mem_lo_q       <= mem_addr_w[7:0];
            nbytes_q       <= (read_nbytes_w == 8'd0) ? 8'd1 : read_nbytes_w;
            i2c_rw         <= 1'b0;
            i2c_nbytes     <= 8'd2;
            i2c_write_data <= mem_addr_w[15:8];
            i2c_start      <= 1'b1;
            cnt            <= '0;
            fall_seen      <= 1'b0;
            state          <= W_START;
          end
        end

        W_START: begin
          if (cnt == CNT_W'(START_CYCLES - 1)) begin
            i2c_start <= 1'b0;
            cnt       <= '0;
            state     <= W_DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // Each tx request falling edge means the master has consumed the offered byte.
        W_DATA: begin
          if (tx_fall) begin
            if (!fall_seen) begin
              i2c_write_data <= mem_lo_q;
              fall_seen      <= 1'b1;
            end else begin
              cnt   <= '0;
              state <= GAP;
            end
          end
        end

        GAP: begin
          if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
            i2c_rw         <= 1'b1;
            i2c_nbytes     <= nbytes_q;
            i2c_write_data <= '0;
            i2c_start      <= 1'b1;
            cnt            <= '0;
            state          <= R_START;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        R_START: begin
          if (cnt == CNT_W'(START_CYCLES - 1)) begin
            i2c_start <= 1'b0;
            cnt       <= '0;
            byte_cnt  <= '0;
            state     <= R_DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        R_DATA: begin
          if (rx_rise) begin
            data_out   <= i2c_read_data;
            byte_ready <= 1'b1;
            byte_cnt   <= byte_cnt + 8'd1;
            if (byte_cnt == nbytes_q - 8'd1) begin
              state <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_read_eeprom.sv
// Bench for read_eeprom: a behavioural I2C master model drives the handshakes
// while expected bytes and transaction fields come from the request itself.
module tb_read_eeprom;

  localparam int unsigned START_CYCLES = 1000;
  localparam int unsigned GAP_CYCLES   = 300;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  slave_addr_w;
  logic [15:0] mem_addr_w;
  logic [7:0]  read_nbytes_w;
  logic        start;
  logic [6:0]  i2c_slave_addr;
  logic        i2c_rw;
  logic [7:0]  i2c_write_data;
  logic [7:0]  i2c_nbytes;
  logic [7:0]  i2c_read_data;
  logic        i2c_tx_data_req;
  logic        i2c_rx_data_ready;
  logic        i2c_start;
  logic [7:0]  data_out;
  logic        byte_ready;

  read_eeprom #(
    .START_CYCLES(START_CYCLES),
    .GAP_CYCLES  (GAP_CYCLES)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .slave_addr_w     (slave_addr_w),
    .mem_addr_w       (mem_addr_w),
    .read_nbytes_w    (read_nbytes_w),
    .start            (start),
    .i2c_slave_addr   (i2c_slave_addr),
    .i2c_rw           (i2c_rw),
    .i2c_write_data   (i2c_write_data),
    .i2c_nbytes       (i2c_nbytes),
    .i2c_read_data    (i2c_read_data),
    .i2c_tx_data_req  (i2c_tx_data_req),
    .i2c_rx_data_ready(i2c_rx_data_ready),
    .i2c_start        (i2c_start),
    .data_out         (data_out),
    .byte_ready       (byte_ready)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] got_q[$];
  logic [7:0] fixed_q[$];
  int         width_err   = 0;
  int         start_rises = 0;
  logic       br_prev     = 1'b0;
  logic       st_prev     = 1'b0;

  // Observer: records every strobed byte, strobe widths and i2c_start launches.
  always @(negedge clk) begin
    if (byte_ready) got_q.push_back(data_out);
    if (byte_ready && br_prev) width_err++;
    if (i2c_start && !st_prev) start_rises++;
    br_prev = byte_ready;
    st_prev = i2c_start;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_start"}, 32'(i2c_start), 0);
    chk({tag, "_byte_ready"}, 32'(byte_ready), 0);
    chk({tag, "_data_out"}, 32'(data_out), 0);
    chk({tag, "_write_data"}, 32'(i2c_write_data), 0);
    chk({tag, "_rw"}, 32'(i2c_rw), 0);
    chk({tag, "_nbytes"}, 32'(i2c_nbytes), 0);
    chk({tag, "_slave_addr"}, 32'(i2c_slave_addr), 0);
  endtask

  // Waits for i2c_start to rise, then measures how many clocks it stays high.
  task automatic wait_start_pulse(input string tag, input int limit);
    int waited = 0;
    int hi;
    while (!i2c_start && waited < limit) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_seen"}, 32'(i2c_start), 1);
    hi = 1;
    while (hi < int'(START_CYCLES) + 50) begin
      @(negedge clk);
      if (!i2c_start) break;
      hi++;
    end
    chk({tag, "_len"}, 32'(hi), START_CYCLES);
  endtask

  // One complete random read; abort_after>0 asserts reset once that many bytes arrived.
  task automatic txn(input logic [6:0] sa, input logic [15:0] ma, input logic [7:0] n,
                     input int abort_after);
    logic [7:0] exp_n;
    logic [7:0] exp_wr[2];
    logic [7:0] exp_q[$];
    logic [7:0] rd;
    int         s0;
    int         g0;
    exp_n     = (n == 8'd0) ? 8'd1 : n;
    exp_wr[0] = ma[15:8];
    exp_wr[1] = ma[7:0];
    got_q.delete();
    width_err = 0;

    start = 1'b0;
    cyc(5);
    slave_addr_w  = sa;
    mem_addr_w    = ma;
    read_nbytes_w = n;
    start         = 1'b1;

    wait_start_pulse("w_start", 40);
    // Request inputs must have been captured; scramble them for the remainder.
    slave_addr_w  = 7'($urandom);
    mem_addr_w    = 16'($urandom);
    read_nbytes_w = 8'($urandom);

    for (int b = 0; b < 2; b++) begin
      cyc($urandom_range(5, 15));
      i2c_tx_data_req = 1'b1;
      cyc($urandom_range(10, 25));
      chk("w_byte", 32'(i2c_write_data), 32'(exp_wr[b]));
      chk("w_rw", 32'(i2c_rw), 0);
      chk("w_nbytes", 32'(i2c_nbytes), 2);
      chk("w_slave", 32'(i2c_slave_addr), 32'(sa));
      i2c_tx_data_req = 1'b0;
    end

    wait_start_pulse("r_start", int'(GAP_CYCLES) + 100);
    chk("r_rw", 32'(i2c_rw), 1);
    chk("r_nbytes", 32'(i2c_nbytes), 32'(exp_n));
    chk("r_slave", 32'(i2c_slave_addr), 32'(sa));
    chk("r_wdata", 32'(i2c_write_data), 0);

    for (int k = 0; k < int'(exp_n); k++) begin
      cyc($urandom_range(5, 15));
      rd = (fixed_q.size() > 0) ? fixed_q.pop_front() : 8'($urandom);
      exp_q.push_back(rd);
      i2c_read_data     = rd;
      i2c_rx_data_ready = 1'b1;
      cyc($urandom_range(8, 20));
      i2c_rx_data_ready = 1'b0;
      i2c_read_data     = 8'($urandom);
      i2c_tx_data_req   = ($urandom_range(0, 1) == 1);
      if (abort_after > 0 && k + 1 == abort_after) begin
        cyc(6);
        chk("abort_bytes_before", 32'(got_q.size()), 32'(abort_after));
        s0 = start_rises;
        g0 = got_q.size();
        reset = 1'b0;
        #1;
        chk_all_zero("abort");
        for (int t = 0; t < 8; t++) begin
          i2c_rx_data_ready = ~i2c_rx_data_ready;
          cyc(4);
        end
        i2c_rx_data_ready = 1'b0;
        i2c_tx_data_req   = 1'b0;
        start             = 1'b0;
        cyc(2);
        reset = 1'b1;
        cyc(300);
        chk("abort_no_start", 32'(start_rises), 32'(s0));
        chk("abort_no_bytes", 32'(got_q.size()), 32'(g0));
        chk("abort_start_low", 32'(i2c_start), 0);
        return;
      end
    end
    i2c_tx_data_req = 1'b0;

    cyc(10);
    chk("r_count", 32'(got_q.size()), 32'(exp_n));
    chk("r_width", 32'(width_err), 0);
    for (int k = 0; k < int'(exp_n) && k < got_q.size(); k++)
      chk("r_data", 32'(got_q[k]), 32'(exp_q[k]));
    chk("r_data_out_hold", 32'(data_out), 32'(exp_q[exp_q.size()-1]));

    // Stays idle afterwards even with start still high.
    s0 = start_rises;
    cyc(200);
    chk("idle_after", 32'(start_rises), 32'(s0));
    chk("idle_data_out", 32'(data_out), 32'(exp_q[exp_q.size()-1]));
  endtask

  initial begin
    int s0;
    reset             = 1'b0;
    start             = 1'b0;
    slave_addr_w      = '0;
    mem_addr_w        = '0;
    read_nbytes_w     = '0;
    i2c_read_data     = '0;
    i2c_tx_data_req   = 1'b0;
    i2c_rx_data_ready = 1'b0;

    // Reset held low with toggling inputs.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start             = ~start;
      slave_addr_w      = 7'($urandom);
      mem_addr_w        = 16'($urandom);
      read_nbytes_w     = 8'($urandom);
      i2c_read_data     = 8'($urandom);
      i2c_tx_data_req   = ~i2c_tx_data_req;
      i2c_rx_data_ready = ~i2c_rx_data_ready;
    end
    chk_all_zero("reset");
    start             = 1'b0;
    i2c_tx_data_req   = 1'b0;
    i2c_rx_data_ready = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc(20);
    chk("post_reset_start", 32'(i2c_start), 0);
    chk("post_reset_rises", 32'(start_rises), 0);
    chk("post_reset_ready", 32'(byte_ready), 0);

    fixed_q.push_back(8'h5A);
    fixed_q.push_back(8'hC3);
    txn(7'h2a, 16'hF0F0, 8'd2, 0);

    txn(7'($urandom), 16'h1234, 8'd1, 0);

    // Start still high from the last request: nothing new may launch.
    s0 = start_rises;
    cyc(500);
    chk("held_start_no_retrigger", 32'(start_rises), 32'(s0));

    txn(7'($urandom), 16'($urandom), 8'd3, 0);
    txn(7'($urandom), 16'($urandom), 8'd0, 0);
    for (int r = 0; r < 2; r++)
      txn(7'($urandom), 16'($urandom), 8'($urandom_range(1, 5)), 0);

    txn(7'($urandom), 16'($urandom), 8'd4, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
